ham_serial_decoder: RTL and testbench

Parametrised serial Hamming decoder and successor to the fixed (7,4) receiver. It decodes a start-bit-framed serial codeword of N = 2^R-1 bits with K = N-R data bits. It corrects single-bit errors, counts error events, and can optionally detect double errors using an extra overall-parity bit. It sits on the receive side of the line-coding chain and feeds parallel data words to downstream logic.

---
 rtl/ham_pkg.sv | 42 ++++
 rtl/ham_syndrome.sv | 36 +++
 rtl/ham_serial_decoder.sv | 138 +++++++++++++
 tb/tb_ham_serial_decoder.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/ham_pkg.sv
// Shared constants, state encoding and position helpers for the serial Hamming decoder.
// Defining HAM_SECDED_EN adds the overall-parity state used for double-error detection.
package ham_pkg;

    localparam logic [1:0] ST_CLEAN  = 2'b00;
    localparam logic [1:0] ST_CORR   = 2'b01;
    localparam logic [1:0] ST_DOUBLE = 2'b10;

`ifdef HAM_SECDED_EN
    typedef enum logic [1:0] {S_IDLE, S_RECV, S_PAR} state_t;
`else
    typedef enum logic [0:0] {S_IDLE, S_RECV} state_t;
`endif

    function automatic int ham_n(input int r);
        return (1 << r) - 1;
    endfunction

    function automatic int ham_k(input int r);
        return (1 << r) - r - 1;
    endfunction

    function automatic bit is_pow2(input int pos);
        return (pos > 0) && ((pos & (pos - 1)) == 0);
    endfunction

    // Code position carrying data bit idx: the idx-th non-power-of-two position, counting from 1.
    function automatic int ham_data_pos(input int idx);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int p = 1; p < 64; p++) begin
            if (!is_pow2(p)) begin
                if (cnt == idx && pos == 0) pos = p;
                cnt++;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/ham_syndrome.sv
// Combinational Hamming syndrome and single-bit correction over a full codeword.
// Codeword bit index equals code position (1..N); shared with the encoder bench.
module ham_syndrome
    import ham_pkg::*;
#(
    parameter  int R = 3,
    localparam int N = ham_n(R),
    localparam int K = ham_k(R)
) (
    input  logic [N:1]   code,
    output logic [R-1:0] syndrome,
    output logic [K-1:0] raw_data,
    output logic [K-1:0] corr_data
);

    logic [N:1] fixed;

    // NOTE: every output of this always_comb gets a default before any conditional update, so no latch is inferred.
    always_comb begin
        syndrome = '0;
        for (int p = 1; p <= N; p++) begin
            if (code[p]) syndrome = syndrome ^ R'(p);
        end

        fixed = code;
        if (syndrome != '0) fixed[syndrome] = ~fixed[syndrome];

        raw_data  = '0;
        corr_data = '0;
        for (int i = 0; i < K; i++) begin
            raw_data[i]  = code[ham_data_pos(i)];
            corr_data[i] = fixed[ham_data_pos(i)];
        end
    end

endmodule

// File: rtl/ham_serial_decoder.sv
// Start-bit-framed serial Hamming decoder with single-error correction and error-event counter.
// Build with HAM_SECDED_EN to receive a trailing overall-parity bit and flag double errors.
module ham_serial_decoder
    import ham_pkg::*;
#(
    parameter  int R     = 3,
    parameter  int CNT_W = 16,
    localparam int N     = ham_n(R),
    localparam int K     = ham_k(R)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in,
    input  logic             clr_cnt,
    output logic             busy,
    output logic             out_valid,
    output logic [K-1:0]     out_data,
    output logic [1:0]       out_status,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [R-1:0] LAST = R'(N);

`ifdef HAM_SECDED_EN
    localparam int SR_W = N;
`else
    // Position N is never stored: decode takes it straight from the line.
    localparam int SR_W = N - 1;
`endif

    state_t          state;
    logic [R-1:0]    bit_idx;
    logic [SR_W:1]   shreg;
    logic [N:1]      code_w;
    logic [R-1:0]    syn;
    logic [K-1:0]    raw;
    logic [K-1:0]    corr;
    logic [K-1:0]    dec_data;
    logic [1:0]      dec_status;

`ifdef HAM_SECDED_EN
    logic q;
    assign code_w = shreg;
    assign q      = ^shreg ^ in;
`else
    assign code_w = {in, shreg};
`endif

    ham_syndrome #(.R(R)) u_syn (
        .code      (code_w),
        .syndrome  (syn),
        .raw_data  (raw),
        .corr_data (corr)
    );

    always_comb begin
        dec_status = ST_CLEAN;
        dec_data   = raw;
`ifdef HAM_SECDED_EN
        if (syn == '0) begin
            if (q) dec_status = ST_CORR;
        end else if (q) begin
            dec_status = ST_CORR;
            dec_data   = corr;
        end else begin
            dec_status = ST_DOUBLE;
        end
`else
        if (syn != '0) begin
            dec_status = ST_CORR;
            dec_data   = corr;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only; the shift register is reset along with the rest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            bit_idx    <= '0;
            shreg      <= '0;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_status <= ST_CLEAN;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in) begin
                        state   <= S_RECV;
                        bit_idx <= R'(1);
                        busy    <= 1'b1;
                    end
                end
                S_RECV: begin
                    bit_idx <= bit_idx + 1'b1;
                    if (bit_idx != LAST) begin
                        shreg[bit_idx] <= in;
                    end else begin
`ifdef HAM_SECDED_EN
                        shreg[N] <= in;
                        state    <= S_PAR;
`else
                        out_valid  <= 1'b1;
                        out_data   <= dec_data;
                        out_status <= dec_status;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
`endif
                    end
                end
`ifdef HAM_SECDED_EN
                S_PAR: begin
                    out_valid  <= 1'b1;
                    out_data   <= dec_data;
                    out_status <= dec_status;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

    // Counts during the out_valid cycle; a clear in that same cycle takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (clr_cnt) begin
            err_count <= '0;
        end else if (out_valid && out_status != ST_CLEAN && err_count != {CNT_W{1'b1}}) begin
            err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_ham_serial_decoder.sv
// Directed bench for ham_serial_decoder (R=3, CNT_W=2); expectations follow HAM_SECDED_EN when defined.
module tb_ham_serial_decoder;

    localparam int N = 7;
`ifdef HAM_SECDED_EN
    localparam int FL = N + 2;
`else
    localparam int FL = N + 1;
`endif

    logic       clk;
    logic       rst_n;
    logic       in;
    logic       clr_cnt;
    logic       busy;
    logic       out_valid;
    logic [3:0] out_data;
    logic [1:0] out_status;
    logic [1:0] err_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_valid_cyc = 0;
    int first_valid_cyc = 0;

    ham_serial_decoder #(.R(3), .CNT_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in         (in),
        .clr_cnt    (clr_cnt),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_status (out_status),
        .err_count  (err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; the rising edge in between samples them.
    task automatic drive(input logic b);
        in = b;
        @(negedge clk);
    endtask

    // seq is written in transmission order: seq[1] is code position 1.
    task automatic send_frame(input string tag, input logic [1:7] seq, input logic par,
                              input logic [3:0] exp_data, input logic [1:0] exp_st);
        drive(1'b1);
        for (int p = 1; p < N; p++) drive(seq[p]);
`ifdef HAM_SECDED_EN
        drive(seq[N]);
`endif
        check({tag, "_busy_before_last"}, busy, 1);
        check({tag, "_valid_before_last"}, out_valid, 0);
`ifdef HAM_SECDED_EN
        drive(par);
`else
        drive(seq[N]);
`endif
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_data"}, out_data, exp_data);
        check({tag, "_status"}, out_status, exp_st);
        last_valid_cyc = cyc;
    endtask

    initial begin
        in      = 1'b0;
        clr_cnt = 1'b0;
        rst_n   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_status", out_status, 0);
        check("rst_count", err_count, 0);
        rst_n = 1'b1;
        @(negedge clk);

        send_frame("clean", 7'b1010101, 1'b0, 4'b1011, 2'b00);
        drive(1'b0);
        check("clean_count", err_count, 0);
        check("clean_valid_drop", out_valid, 0);

        send_frame("flip6", 7'b1010111, 1'b0, 4'b1011, 2'b01);
        drive(1'b0);
        check("flip6_count", err_count, 1);

        send_frame("flip2", 7'b1110101, 1'b0, 4'b1011, 2'b01);
        drive(1'b0);
        check("flip2_count", err_count, 2);

`ifdef HAM_SECDED_EN
        send_frame("double", 7'b1000001, 1'b0, 4'b1000, 2'b10);
`else
        send_frame("double", 7'b1000001, 1'b0, 4'b1100, 2'b01);
`endif
        drive(1'b0);
        check("double_count", err_count, 3);

        send_frame("sat", 7'b1010111, 1'b0, 4'b1011, 2'b01);
        drive(1'b0);
        check("sat_count", err_count, 3);

        send_frame("clr", 7'b1010111, 1'b0, 4'b1011, 2'b01);
        clr_cnt = 1'b1;
        drive(1'b0);
        clr_cnt = 1'b0;
        check("clr_count", err_count, 0);

`ifdef HAM_SECDED_EN
        send_frame("par_err", 7'b1010101, 1'b1, 4'b1011, 2'b01);
        drive(1'b0);
        check("par_err_count", err_count, 1);
`endif

        send_frame("b2b_a", 7'b1010101, 1'b0, 4'b1011, 2'b00);
        first_valid_cyc = last_valid_cyc;
        send_frame("b2b_b", 7'b1100110, 1'b0, 4'b0110, 2'b00);
        check("b2b_spacing", last_valid_cyc - first_valid_cyc, FL);
        drive(1'b0);

        send_frame("pre_rst", 7'b1110101, 1'b0, 4'b1011, 2'b01);
        drive(1'b0);
`ifdef HAM_SECDED_EN
        check("pre_rst_count", err_count, 2);
`else
        check("pre_rst_count", err_count, 1);
`endif

        // Abort a frame while position 4 is on the line.
        drive(1'b1);
        drive(1'b1);
        drive(1'b1);
        drive(1'b0);
        in = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_valid", out_valid, 0);
        check("midrst_data", out_data, 0);
        check("midrst_status", out_status, 0);
        check("midrst_count", err_count, 0);
        @(negedge clk);
        drive(1'b1);
        drive(1'b0);
        check("midrst_hold_valid", out_valid, 0);
        check("midrst_hold_busy", busy, 0);
        rst_n = 1'b1;
        drive(1'b0);
        drive(1'b0);
        check("post_rst_idle_valid", out_valid, 0);

        send_frame("post_rst", 7'b1100110, 1'b0, 4'b0110, 2'b00);
        drive(1'b0);
        check("post_rst_count", err_count, 0);
        check("post_rst_busy_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
